// File: rtl/pwm_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pwm_bank
// Purpose  : Multi-channel PWM generator with prescaler, shadowed duty
//            registers and a register-mapped configuration port.
// Revision : 1.0
// ============================================================================
module pwm_bank #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int PRESC_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                cfg_we,
    input  logic                cfg_re,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]    cfg_wdata,
    output logic [WIDTH-1:0]    cfg_rdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic [WIDTH-1:0]  c_cnt_last   = WIDTH'((2 ** WIDTH) - 2);
    localparam logic [ADDR_W-1:0] c_addr_oe    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_addr_pe    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_presc = ADDR_W'(2);

    logic [CHANNELS-1:0] r_out_en;
    logic [CHANNELS-1:0] r_pwm_en;
    logic [PRESC_W-1:0]  r_presc;
    logic [PRESC_W-1:0]  r_pc;
    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_duty   [CHANNELS];
    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_start;
    logic [WIDTH-1:0]    r_rdata;

    logic                w_tick;
    logic                w_wrap;
    logic [WIDTH-1:0]    w_cnt_nxt;
    logic                w_presc_we;
    logic [CHANNELS-1:0] w_pwm_nxt;
    logic [WIDTH-1:0]    w_rd;

    assign w_tick     = ena && (r_pc == r_presc);
    assign w_wrap     = w_tick && (r_cnt == c_cnt_last);
    assign w_cnt_nxt  = w_wrap ? '0 : (w_tick ? r_cnt + WIDTH'(1) : r_cnt);
    assign w_presc_we = cfg_we && (cfg_addr == c_addr_presc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_en <= '0;
            r_pwm_en <= '0;
            r_presc  <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == c_addr_oe)    r_out_en <= cfg_wdata[CHANNELS-1:0];
            if (cfg_addr == c_addr_pe)    r_pwm_en <= cfg_wdata[CHANNELS-1:0];
            if (cfg_addr == c_addr_presc) r_presc  <= cfg_wdata[PRESC_W-1:0];
        end
    end

    // A PRESC write restarts the prescale phase; the period position is kept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc           <= '0;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_presc_we) begin
                r_pc <= '0;
            end else if (ena) begin
                r_pc <= w_tick ? '0 : r_pc + PRESC_W'(1);
            end
            r_cnt          <= w_cnt_nxt;
            r_period_start <= w_wrap;
        end
    end

    // Output looks ahead at next cnt/shadow so the first value of a new
    // period lands together with period_start.
    always_comb begin
        w_pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!r_out_en[i]) begin
                w_pwm_nxt[i] = 1'b0;
            end else if (!r_pwm_en[i]) begin
                w_pwm_nxt[i] = 1'b1;
            end else begin
                w_pwm_nxt[i] = w_cnt_nxt < (w_wrap ? r_duty[i] : r_shadow[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i]   <= '0;
                r_shadow[i] <= '0;
            end
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_we && (cfg_addr == ADDR_W'(i + 4))) r_duty[i] <= cfg_wdata;
                if (w_wrap) r_shadow[i] <= r_duty[i];
            end
            if (ena) r_pwm <= w_pwm_nxt;
        end
    end

    always_comb begin
        w_rd = '0;
        case (cfg_addr)
            c_addr_oe:    w_rd[CHANNELS-1:0] = r_out_en;
            c_addr_pe:    w_rd[CHANNELS-1:0] = r_pwm_en;
            c_addr_presc: w_rd[PRESC_W-1:0]  = r_presc;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (cfg_addr == ADDR_W'(i + 4)) w_rd = r_duty[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (cfg_re) begin
            r_rdata <= w_rd;
        end
    end

    assign cfg_rdata    = r_rdata;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_bank
// Purpose  : Randomised scoreboard bench for pwm_bank with period measurements.
// Revision : 1.0
// ============================================================================
module tb_pwm_bank;

    localparam int CH  = 8;
    localparam int MAX = 255;

    logic       clk = 1'b0;
    logic       rst_n, ena, cfg_we, cfg_re;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata, cfg_rdata, pwm_out;
    logic       period_start;

    always #5 clk = ~clk;

    pwm_bank #(.CHANNELS(8), .WIDTH(8), .ADDR_W(4), .PRESC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_re(cfg_re),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .pwm_out(pwm_out), .period_start(period_start)
    );

    typedef struct {
        logic [7:0] pwm;
        logic       ps;
        logic [7:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state, kept as plain integers
    int m_oe, m_pe, m_presc, m_pc, m_cnt, m_pwm, m_ps, m_rd;
    int m_duty[CH];
    int m_sh[CH];

    // Period measurements taken from the DUT outputs
    int nps = 0;
    int acc_len = 0, last_len = 0;
    int acc_hi[3];
    int last_hi[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int reg_val(input int a);
        if (a == 0) return m_oe;
        if (a == 1) return m_pe;
        if (a == 2) return m_presc;
        if (a >= 4 && a < 4 + CH) return m_duty[a - 4];
        return 0;
    endfunction

    task automatic model_reset();
        m_oe = 0; m_pe = 0; m_presc = 0; m_pc = 0; m_cnt = 0;
        m_pwm = 0; m_ps = 0; m_rd = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            m_sh[i]   = 0;
        end
    endtask

    task automatic step(input bit we, input bit re, input int a, input int d, input bit en, input bit rn);
        int   tick, wrap, ncnt, b;
        exp_t e;
        @(negedge clk);
        rst_n = rn; ena = en; cfg_we = we; cfg_re = re;
        cfg_addr = 4'(a); cfg_wdata = 8'(d);
        if (!rn) begin
            model_reset();
        end else begin
            if (re) m_rd = reg_val(a);
            tick = (en && m_pc == m_presc) ? 1 : 0;
            wrap = (tick != 0 && m_cnt == MAX - 1) ? 1 : 0;
            ncnt = (tick != 0) ? (m_cnt + 1) % MAX : m_cnt;
            if (wrap != 0) for (int i = 0; i < CH; i++) m_sh[i] = m_duty[i];
            if (en) begin
                m_pwm = 0;
                for (int i = 0; i < CH; i++) begin
                    if (((m_oe >> i) & 1) == 0)      b = 0;
                    else if (((m_pe >> i) & 1) == 0) b = 1;
                    else                             b = (ncnt < m_sh[i]) ? 1 : 0;
                    m_pwm = m_pwm | (b << i);
                end
            end
            if (we && a == 2) m_pc = 0;
            else if (en)      m_pc = (tick != 0) ? 0 : m_pc + 1;
            m_cnt = ncnt;
            m_ps  = wrap;
            if (we) begin
                if (a == 0) m_oe = d & 8'hFF;
                if (a == 1) m_pe = d & 8'hFF;
                if (a == 2) m_presc = d & 4'hF;
                if (a >= 4 && a < 4 + CH) m_duty[a - 4] = d & 8'hFF;
            end
        end
        e.pwm = m_pwm[7:0];
        e.ps  = m_ps[0];
        e.rd  = m_rd[7:0];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, 1);
    endtask

    task automatic wr(input int a, input int d);
        step(1, 0, a, d, 1, 1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_ps(input int budget);
        int seen = 0;
        for (int k = 0; k < budget && seen == 0; k++) begin
            step(0, 0, 0, 0, 1, 1);
            if (m_ps != 0) seen = 1;
        end
        chk("ps_wait", seen, 1);
        settle();
    endtask

    task automatic meas(input string tag, input int len, input int h0, input int h1, input int h2);
        chk({tag, "_len"}, last_len, len);
        chk({tag, "_hi0"}, last_hi[0], h0);
        if (h1 >= 0) chk({tag, "_hi1"}, last_hi[1], h1);
        if (h2 >= 0) chk({tag, "_hi2"}, last_hi[2], h2);
    endtask

    // Monitor: pops one expectation per clock and measures periods
    initial begin
        exp_t e;
        for (int i = 0; i < 3; i++) acc_hi[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pwm_out", pwm_out, e.pwm);
                chk("period_start", period_start, e.ps);
                chk("cfg_rdata", cfg_rdata, e.rd);
            end
            if (!rst_n) nps = 0;
            if (period_start) begin
                if (nps > 0) begin
                    last_len = acc_len;
                    for (int i = 0; i < 3; i++) last_hi[i] = acc_hi[i];
                end
                nps++;
                acc_len = 0;
                for (int i = 0; i < 3; i++) acc_hi[i] = 0;
            end
            acc_len++;
            for (int i = 0; i < 3; i++) if (pwm_out[i]) acc_hi[i]++;
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_addr = '0; cfg_wdata = '0;
        model_reset();

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 16; a++) step(0, 1, a, 0, 1, 1);

        // Static high on channel 0, then off
        wr(0, 8'h01);
        idle(3);
        wr(0, 8'h00);
        idle(3);

        // Duty ratio at PRESC=0
        wr(2, 0); wr(0, 8'hFF); wr(1, 8'hFF);
        wr(4, 8'h80); wr(5, 8'h00); wr(6, 8'hFF);
        run_until_ps(600);
        run_until_ps(600);
        meas("duty", 255, 128, 0, 255);

        // Prescaler and ena freeze
        wr(2, 3); wr(4, 8'h40);
        run_until_ps(1200);
        run_until_ps(1200);
        meas("presc", 1020, 256, -1, -1);
        idle(300);
        for (int k = 0; k < 50; k++) step(0, 0, 0, 0, 0, 1);
        run_until_ps(1300);
        meas("freeze", 1070, 256, -1, -1);

        // Shadowing: mid-period change, then a write coincident with the wrap
        wr(2, 0); wr(4, 8'h80);
        run_until_ps(1200);
        run_until_ps(600);
        idle(50);
        wr(4, 8'h20);
        run_until_ps(600);
        meas("shadow_old", 255, 128, -1, -1);
        run_until_ps(600);
        meas("shadow_new", 255, 32, -1, -1);
        for (int k = 0; k < 600 && !(m_cnt == MAX - 1 && m_pc == m_presc); k++) idle(1);
        wr(4, 8'h60);
        chk("coincident_wrap", m_ps, 1);
        run_until_ps(600);
        meas("coinc_old", 255, 32, -1, -1);
        run_until_ps(600);
        meas("coinc_new", 255, 96, -1, -1);

        // Out-of-range address, same-cycle read/write, mid-period reset
        wr(15, 8'hFF);
        step(0, 1, 15, 0, 1, 1);
        for (int a = 0; a < 12; a++) step(0, 1, a, 0, 1, 1);
        step(1, 1, 0, 8'h5A, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        idle(100);
        step(0, 0, 0, 0, 1, 0);
        idle(5);
        for (int a = 0; a < 12; a++) step(0, 1, a, 0, 1, 1);

        // Randomised traffic
        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                 $urandom_range(0, 15) != 0, $urandom_range(0, 999) != 0);
        end

        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator with a register-mapped configuration port. It generalises the single-bank 8-channel onboarding PWM peripheral to CHANNELS outputs of WIDTH-bit resolution. It adds a clock prescaler, per-channel shadowed duty registers updated only at period boundaries, and registered read-back. It sits behind the SPI register decoder inside the tt_um top, driving uo_out/uio_out directly.

## Interface

- CHANNELS, 8, number of PWM outputs; 1..WIDTH
- WIDTH, 8, duty/counter resolution and register data width; 2..16
- ADDR_W, 4, config address width; CHANNELS+4 <= 2**ADDR_W
- PRESC_W, 4, prescaler register width; <= WIDTH
- clk  in  1  clock (the single clock)
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  design enable; low freezes counting
- cfg_we  in  1  write strobe, one word per cycle
- cfg_re  in  1  read strobe
- cfg_addr  in  ADDR_W  register address (shared by read and write)
- cfg_wdata  in  WIDTH  write data
- cfg_rdata  out  WIDTH  read data, valid cycle after cfg_re
- pwm_out  out  CHANNELS  PWM outputs, registered
- period_start  out  1  one-cycle pulse when a new PWM period begins

## Operation

- Register map:
  - 0 = OUT_EN[CHANNELS-1:0]
  - 1 = PWM_EN[CHANNELS-1:0]
  - 2 = PRESC[PRESC_W-1:0]
  - 3 = reserved (reads 0)
  - 4+i = DUTY[i]
- Unused upper bits read 0. Writes to addresses >= CHANNELS+4 are ignored; reads there return 0.
- Prescaler: counter pc counts 0..PRESC while ena=1; tick asserts on the cycle pc==PRESC, then pc returns to 0. PRESC=0 gives a tick every cycle.
- Period counter cnt, WIDTH bits, advances on tick, counting 0..MAX-1 with MAX=2**WIDTH-1. Wraps MAX-1 -> 0. Period = MAX ticks (255 for WIDTH=8).
- Shadow duty SH[i] loads from DUTY[i] on the tick where cnt wraps MAX-1 -> 0. The same tick registers period_start=1.
- Per-channel next output:
  - OUT_EN[i]=0 -> 0
  - OUT_EN[i]=1, PWM_EN[i]=0 -> 1 (static high)
  - otherwise -> (cnt < SH[i])
- Consequences: DUTY=0 gives always low; DUTY=MAX (all ones) gives always high (100%).
- ena=0: pc, cnt and SH hold; pwm_out holds last value; period_start=0. Config writes and reads still operate.
- A write to PRESC resets pc to 0 the next cycle. cnt is unaffected.
- Same-cycle cfg_we and cfg_re to the same address: read returns the old value.
- Same-cycle DUTY write and shadow-load tick: the shadow captures the old DUTY; the new value applies next period.

## Timing

- Reset (rst_n=0 at a clk edge): all registers, pc, cnt, SH, cfg_rdata, pwm_out and period_start become 0. Reset mid-period aborts immediately with no partial-period completion.
- Config write at edge N is visible in registers after edge N. The OUT_EN/PWM_EN effect appears on pwm_out after edge N+1 (one cycle of output register latency).
- A DUTY write affects pwm_out only from the first period_start after the write.
- cfg_rdata updates on the edge after cfg_re. It holds its value when cfg_re=0.
- pwm_out and period_start are registered. period_start is high for exactly one clk cycle, coincident with the first pwm_out value of the new period.

## Test plan

- Reset: after rst_n low for 2 cycles, pwm_out=0, cfg_rdata=0, period_start=0. Read of every address returns 0.
- Static enable: write OUT_EN=0x01 with PWM_EN=0 -> pwm_out[0]=1 two cycles after the write edge. Write OUT_EN=0 -> pwm_out[0]=0.
- Duty ratio (WIDTH=8, PRESC=0): OUT_EN=PWM_EN=0xFF, DUTY0=0x80, DUTY1=0x00, DUTY2=0xFF. Over one full period (255 cycles) measured between period_start pulses, ch0 high for exactly 128 cycles, ch1 never high, ch2 always high.
- Prescaler: PRESC=3, DUTY0=0x40 -> period 1020 cycles, ch0 high for 256 cycles. ena held low for 50 cycles mid-period -> the high count remains 256 and the period extends by 50.
- Shadowing: change DUTY0 0x80->0x20 mid-period -> current period keeps 128 high cycles, next period has 32. A write coincident with the wrap tick takes effect one period later.
- Boundaries: write/read address 15 (CHANNELS=8) -> no register changes, rdata=0. Reset asserted mid-period -> outputs 0 next cycle, counting restarts from cnt=0.
